// File: rtl/ru_pkg.sv
// Shared types for the vertex feature read-modify-write pipeline.
package ru_pkg;

  localparam int RU_ADDRW = 16;
  localparam int RU_WL    = 32;

  typedef enum logic [1:0] {
    RU_ADD     = 2'd0,
    RU_MAX     = 2'd1,
    RU_MIN     = 2'd2,
    RU_REPLACE = 2'd3
  } ru_mode_e;

  typedef struct packed {
    logic                valid;
    logic [RU_ADDRW-1:0] dst;
    logic [RU_WL-1:0]    value;
    ru_mode_e            mode;
  } ru_stage_t;

endpackage

// File: rtl/ru_reduce_op.sv
// Reduce operator: combines feature and value, then OPLAT ce-gated stages.
module ru_reduce_op
  import ru_pkg::*;
#(
  parameter int ADDRW = RU_ADDRW,
  parameter int WL    = RU_WL,
  parameter int OPLAT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        v_i,
  input  logic [ADDRW-1:0]            dst_i,
  input  logic [WL-1:0]               a_i,
  input  logic [WL-1:0]               b_i,
  input  ru_mode_e                    mode_i,
  output logic [OPLAT-1:0]            v_o,
  output logic [OPLAT-1:0][ADDRW-1:0] dst_o,
  output logic [WL-1:0]               res_o
);

  logic [WL-1:0]               res_d;
  logic [OPLAT-1:0]            v_q;
  logic [OPLAT-1:0][ADDRW-1:0] dst_q;
  logic [OPLAT-1:0][WL-1:0]    res_q;

  // ties in max/min keep the stored feature (a_i)
  always_comb begin
    res_d = a_i;
    unique case (mode_i)
      RU_ADD:     res_d = a_i + b_i;
      RU_MAX:     res_d = ($signed(b_i) > $signed(a_i)) ? b_i : a_i;
      RU_MIN:     res_d = ($signed(b_i) < $signed(a_i)) ? b_i : a_i;
      RU_REPLACE: res_d = b_i;
      default:    res_d = a_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      dst_q <= '0;
      res_q <= '0;
    end else if (ce) begin
      v_q[0]   <= v_i;
      dst_q[0] <= dst_i;
      res_q[0] <= res_d;
      for (int i = 1; i < OPLAT; i++) begin
        v_q[i]   <= v_q[i-1];
        dst_q[i] <= dst_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

  assign v_o   = v_q;
  assign dst_o = dst_q;
  assign res_o = res_q[OPLAT-1];

endmodule

// File: rtl/ru_update_pipe.sv
// Vertex feature update pipeline: read, reduce, write with RAW interlock.
module ru_update_pipe
  import ru_pkg::*;
#(
  parameter int ADDRW = RU_ADDRW,
  parameter int WL    = RU_WL,
  parameter int RDLAT = 2,
  parameter int OPLAT = 3,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             stall,
  input  logic             wr_stall,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADDRW-1:0] in_dst,
  input  logic [WL-1:0]    in_value,
  output logic [ADDRW-1:0] rd_addr,
  output logic             rd_en,
  output logic             rd_ce,
  input  logic [WL-1:0]    rd_data,
  output logic             wr_en,
  output logic [ADDRW-1:0] wr_addr,
  output logic [WL-1:0]    wr_data,
  output logic [CNTW-1:0]  hazard_cnt
);

  typedef struct packed {
    logic             valid;
    logic [ADDRW-1:0] dst;
    logic [WL-1:0]    value;
    ru_mode_e         mode;
  } stg_t;

  logic                        adv;
  logic                        hit;
  logic                        hz;
  stg_t                        stg_d;
  stg_t                        stg_q [1:RDLAT];
  logic [OPLAT-1:0]            op_v;
  logic [OPLAT-1:0][ADDRW-1:0] op_dst;
  logic [WL-1:0]               op_res;
  logic [CNTW-1:0]             cnt_q;
  logic [CNTW-1:0]             cnt_d;

  assign adv = ena & ~stall & ~wr_stall & ~rst;

  // every in-flight stage, including the one writing now, blocks its dst
  always_comb begin
    hit = 1'b0;
    for (int k = 1; k <= RDLAT; k++) begin
      hit = hit | (stg_q[k].valid && stg_q[k].dst == in_dst);
    end
    for (int j = 0; j < OPLAT; j++) begin
      hit = hit | (op_v[j] && op_dst[j] == in_dst);
    end
  end

  assign hz       = in_valid & hit;
  assign in_ready = adv & ~hz;
  assign rd_en    = in_valid & in_ready;
  assign rd_addr  = in_dst;
  assign rd_ce    = adv;

  assign stg_d = '{
    valid: rd_en,
    dst:   in_dst,
    value: in_value,
    mode:  ru_mode_e'(mode)
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= RDLAT; k++) begin
        stg_q[k] <= '0;
      end
    end else if (adv) begin
      stg_q[1] <= stg_d;
      for (int k = 2; k <= RDLAT; k++) begin
        stg_q[k] <= stg_q[k-1];
      end
    end
  end

  ru_reduce_op #(
    .ADDRW (ADDRW),
    .WL    (WL),
    .OPLAT (OPLAT)
  ) u_op (
    .clk    (clk),
    .rst    (rst),
    .ce     (adv),
    .v_i    (stg_q[RDLAT].valid),
    .dst_i  (stg_q[RDLAT].dst),
    .a_i    (rd_data),
    .b_i    (stg_q[RDLAT].value),
    .mode_i (stg_q[RDLAT].mode),
    .v_o    (op_v),
    .dst_o  (op_dst),
    .res_o  (op_res)
  );

  assign wr_en   = op_v[OPLAT-1] & adv;
  assign wr_addr = op_dst[OPLAT-1];
  assign wr_data = op_res;

  assign cnt_d = (adv & hz) ? cnt_q + CNTW'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_ru_update_pipe.sv
// Directed bench for ru_update_pipe with a 2-cycle read memory model.
module tb_ru_update_pipe;

  localparam int N = 5;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        stall;
  logic        wr_stall;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dst;
  logic [31:0] in_value;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic        rd_ce;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] hazard_cnt;

  ru_update_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .stall      (stall),
    .wr_stall   (wr_stall),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dst     (in_dst),
    .in_value   (in_value),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_ce      (rd_ce),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .hazard_cnt (hazard_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // feature memory model: preload port, write port, 2-stage read pipe
  logic [31:0] mem [0:255];
  logic [31:0] p1, p2;
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [31:0] pl_d;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (wr_en) mem[wr_addr[7:0]] <= wr_data;
    if (rd_ce) begin
      p1 <= mem[rd_addr[7:0]];
      p2 <= p1;
    end
  end
  assign rd_data = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) begin
    if (wr_en) wq.push_back('{cyc, wr_addr, wr_data});
  end

  typedef struct {
    logic [15:0] dst;
    logic [31:0] feat;
    logic [31:0] val;
    logic [1:0]  md;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [7];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pl(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic get_wr(output wr_t w, output bit ok);
    ok = 1'b0;
    w  = '{0, 16'h0, 32'h0};
    for (int i = 0; i < 40; i++) begin
      if (wq.size() > 0) begin
        w  = wq.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    wr_t w;
    bit  ok;
    int  t0, ta, tb, acc, bad, k;
    bit  rdy_all;

    vt[0] = '{16'h0005, 32'd10,       32'd3,        2'd0, 32'd13};
    vt[1] = '{16'h0020, 32'hFFFFFFFC, 32'd7,        2'd0, 32'd3};
    vt[2] = '{16'h0021, 32'hFFFFFFFC, 32'd7,        2'd1, 32'd7};
    vt[3] = '{16'h0022, 32'hFFFFFFFC, 32'd7,        2'd2, 32'hFFFFFFFC};
    vt[4] = '{16'h0023, 32'hFFFFFFFC, 32'd7,        2'd3, 32'd7};
    vt[5] = '{16'h0024, 32'hFFFFFFFC, 32'hFFFFFFFC, 2'd1, 32'hFFFFFFFC};
    vt[6] = '{16'h0025, 32'h7FFFFFFF, 32'd1,        2'd0, 32'h80000000};

    rst = 1'b1; ena = 1'b1; stall = 1'b0; wr_stall = 1'b0;
    mode = 2'd0; in_valid = 1'b1; in_dst = '0; in_value = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_hazard_cnt", hazard_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_en", rd_en, 0);
    tick();
    rst = 1'b0; ena = 1'b0;
    @(negedge clk);
    chk("ena0_in_ready", in_ready, 0);
    chk("ena0_rd_ce", rd_ce, 0);
    tick();
    in_valid = 1'b0; ena = 1'b1;

    for (int i = 0; i < 7; i++) begin
      pl(vt[i].dst[7:0], vt[i].feat);
      in_valid = 1'b1; in_dst = vt[i].dst;
      in_value = vt[i].val; mode = vt[i].md;
      t0 = cyc;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0; mode = 2'd3;
      get_wr(w, ok);
      chk($sformatf("v%0d_seen", i), ok, 1);
      chk($sformatf("v%0d_addr", i), w.a, vt[i].dst);
      chk($sformatf("v%0d_data", i), w.d, vt[i].exp);
      chk($sformatf("v%0d_lat", i), w.c - t0, N);
      tick();
    end
    chk("vec_hazard_cnt", hazard_cnt, 0);

    // same destination twice, second held until the first retires
    pl(8'd9, 32'd100);
    in_valid = 1'b1; in_dst = 16'd9; in_value = 32'd5; mode = 2'd0;
    acc = 0; ta = 0; tb = 0;
    for (int i = 0; i < 20 && acc < 2; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (acc == 0) ta = cyc;
        else tb = cyc;
        acc++;
      end
      tick();
      if (acc == 1) in_value = 32'd7;
    end
    in_valid = 1'b0;
    chk("raw_accepts", acc, 2);
    chk("raw_gap", tb - ta, N + 1);
    chk("raw_hazard_cnt", hazard_cnt, 5);
    get_wr(w, ok);
    chk("raw_w1", w.d, 32'd105);
    get_wr(w, ok);
    chk("raw_w2_addr", w.a, 16'd9);
    chk("raw_w2_data", w.d, 32'd112);
    tick();

    // distinct destinations stream without bubbles
    for (int i = 1; i <= 4; i++) pl(8'(i), 32'(10 * i));
    rdy_all = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_dst = 16'(i); in_value = 32'(i); mode = 2'd0;
      @(negedge clk);
      if (!in_ready) rdy_all = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk("dist_ready", rdy_all, 1);
    t0 = 0;
    for (int i = 1; i <= 4; i++) begin
      get_wr(w, ok);
      chk($sformatf("dist%0d_addr", i), w.a, 16'(i));
      chk($sformatf("dist%0d_data", i), w.d, 32'(11 * i));
      if (i > 1) chk($sformatf("dist%0d_gap", i), w.c - t0, 1);
      t0 = w.c;
    end
    tick();

    // writeback stall with three items in flight
    for (int i = 0; i < 3; i++) pl(8'(8'h30 + i), 32'(100 * (i + 1)));
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dst = 16'(16'h30 + i);
      in_value = 32'(i + 1); mode = 2'd0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    wr_stall = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wr_en || in_ready || rd_ce) bad++;
      tick();
    end
    wr_stall = 1'b0;
    chk("stall_frozen", bad, 0);
    chk("stall_no_wr", wq.size(), 0);
    for (int i = 0; i < 3; i++) begin
      get_wr(w, ok);
      chk($sformatf("stall%0d_addr", i), w.a, 16'(16'h30 + i));
      chk($sformatf("stall%0d_data", i), w.d, 32'(101 * (i + 1)));
      chk($sformatf("stall%0d_cyc", i), w.c, k + N + 3 + i);
    end
    tick();

    // reset with four items in flight
    for (int i = 0; i < 4; i++) pl(8'(8'h40 + i), 32'd50);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dst = 16'(16'h40 + i);
      in_value = 32'd9; mode = 2'd0;
      tick();
    end
    in_dst = 16'h40;
    @(negedge clk);
    chk("mid_hz_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_hazard_cnt", hazard_cnt, 6);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    tick();
    rst = 1'b0; in_value = 32'd1;
    k = cyc;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_hazard_cnt", hazard_cnt, 0);
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    chk("post_rst_nwr", wq.size(), 1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      chk("post_rst_addr", w.a, 16'h40);
      chk("post_rst_data", w.d, 32'd51);
      chk("post_rst_cyc", w.c, k + N);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ru_update_pipe.md
Name: ru_update_pipe

Overview:
- Read-modify-write update pipeline for vertex feature memory in the graph-processing datapath; parametrised successor of the single-mode reduce/update pipeline.
- Accepts (dst, value) updates, issues the feature read, combines the returned feature with value using a selectable operator, and emits the memory write.
- Adds configurable read and operator latencies, selectable reduce operator, a RAW-hazard interlock on in-flight destinations, a ready handshake and a hazard stall counter.

Parameters:
ADDRW, 16, vertex address width
WL, 32, feature/value word width (two's complement)
RDLAT, 2, feature memory read latency in advance cycles (>=1)
OPLAT, 3, operator pipeline latency in advance cycles (>=1)
CNTW, 32, hazard counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ena  in  1  global enable; low freezes the pipeline
stall  in  1  upstream/global stall; freezes the pipeline
wr_stall  in  1  writeback backpressure; freezes the pipeline
mode  in  2  operator for the offered update: 0 add, 1 signed max, 2 signed min, 3 replace
in_valid  in  1  update offered
in_ready  out  1  update accepted this cycle when in_valid&in_ready
in_dst  in  ADDRW  destination vertex address
in_value  in  WL  update value
rd_addr  out  ADDRW  feature read address (= in_dst, combinational)
rd_en  out  1  = in_valid & in_ready
rd_ce  out  1  clock enable for the memory read pipeline (= adv)
rd_data  in  WL  feature returned RDLAT rd_ce cycles after rd_en
wr_en  out  1  write feature
wr_addr  out  ADDRW  write address
wr_data  out  WL  combined result
hazard_cnt  out  CNTW  number of cycles in which an update was refused because of a hazard

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- adv = ena & ~stall & ~wr_stall & ~rst. All pipeline registers and the carried fields update only when adv=1 and hold otherwise.
- N = RDLAT+OPLAT stages, each holding {valid, dst, value, mode}.
- Stage 0 is the accept point. rd_data pairs with the item at stage RDLAT.
- The operator result is computed when the item moves from stage RDLAT to RDLAT+1, then delayed to stage N.
- wr_en = stage N valid & adv, with wr_addr/wr_data taken from stage N.
- Latency: accept at advance cycle T gives wr_en at T+N advance cycles.
- Hazard: hz = in_valid & OR over stages k=1..N of (valid_k & dst_k==in_dst). Stage N is included, so a read is never issued in the same cycle as a write to that address.
- in_ready = adv & ~hz.
- When in_valid & ~in_ready & adv, a bubble (valid=0) enters stage 0. The same bubble entry applies when in_valid=0.
- Arithmetic, all WL bits:
  - add: wrapping two's-complement sum of rd_data and value, no saturation.
  - max/min: signed compare; on a tie the result is rd_data.
  - replace: result = value; rd_data is ignored, but the read is still issued.
- mode is sampled at accept and travels with the item. Changing mode mid-flight never affects accepted items.
- Back-to-back updates to the same dst: the second is accepted N+1 cycles after the first, after N bubbles.
- Back-to-back updates to distinct dst: one accepted per adv cycle, no bubbles.
- hazard_cnt increments by 1 on each cycle with adv & in_valid & hz; it wraps at 2^CNTW.
- Reset values:
  - all stage valids 0; wr_en 0; wr_addr 0; wr_data 0; hazard_cnt 0.
  - in_ready 0 and rd_en 0 during rst.
- Reset mid-operation drops every in-flight update; no write is emitted after rst is asserted.
- Freeze: while adv=0, in_ready=0 and rd_ce=0, and wr_en is held low. The stage N contents stay and are written on the first adv cycle.

Decomposition:
- Package ru_pkg holds:
  - mode encodings: RU_ADD=0, RU_MAX=1, RU_MIN=2, RU_REPLACE=3
  - default ADDRW/WL constants
  - stage record typedef {valid, dst, value, mode}
- Sub-module ru_reduce_op:
  - inputs: ce, a=rd_data, b=value, mode
  - output: result after OPLAT ce-gated register stages, plus matching valid/dst pass-through
- Top level holds the read-latency stages, the hazard comparator array and the counter.

Test Plan:
- Single add, RDLAT=2, OPLAT=3: accept dst=5 value=3 with rd_data=10 -> wr_en exactly 5 cycles later, wr_addr=5, wr_data=13, hazard_cnt=0.
- Mode sweep, feature=-4 (0xFFFFFFFC), value=7: add -> 3; max -> 7; min -> -4; replace -> 7. A max tie with value=-4 -> -4.
- Same-dst pair: dst=9 offered at T and held -> second accepted at T+6, hazard_cnt=5. Its read returns the first write's result; final wr_data = feature+v1+v2.
- Distinct dsts 1,2,3,4 on consecutive cycles -> in_ready constant 1; four consecutive wr_en with addresses 1,2,3,4.
- wr_stall asserted for 3 cycles while 3 items are in flight -> no movement and wr_en=0 during the stall; after release, writes resume in order with unchanged data.
- rst pulsed with 4 items in flight -> no wr_en afterward; hazard_cnt=0; in_ready=1 on the first cycle after rst deasserts (ena=1, no stalls).
- Add overflow: feature=0x7FFFFFFF, value=1 -> wr_data=0x80000000.
